// File: rtl/uart_pkg.sv
// Shared definitions for the UART line engines: FSM state encoding,
// oversampling constants and frame-format helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  // Length code 0..3 selects 6..9 data bits.
  function automatic logic [3:0] length_to_bits(input logic [1:0] code);
    return 4'd6 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample prescaler: one-clock tick every i_clk_div+1 clocks,
// restarted from zero while i_clr is high.
module uart_os_tick (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic [15:0] i_clk_div,
  output logic        o_tick
);

  logic [15:0] cnt;

  assign o_tick = (cnt == i_clk_div) && !i_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (cnt == i_clk_div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled, 2-of-3 majority per bit, runtime
// frame format (6-9 data bits, optional parity, 1/2 stop bits).
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_clk_div,
  input  logic        i_rxen,
  input  logic [1:0]  i_length,
  input  logic        i_stop2,
  input  logic        i_parity,
  input  logic        i_odd,
  input  logic        i_rx,
  output logic [8:0]  o_data,
  output logic        o_valid,
  output logic        o_parity_err,
  output logic        o_frame_err,
  output logic        o_busy
);
  import uart_pkg::*;

  localparam logic [3:0] TC_LAST = 4'(OVERSAMPLE - 1);

  state_t      state_q, state_d;
  logic        rx_meta, rx_s, rx_d;
  logic [3:0]  nbits_q;
  logic        stop2_q, parity_q, odd_q;
  logic [15:0] div_q;
  logic        tick;
  logic [3:0]  tc;
  logic        s7, s8;
  logic [8:0]  shreg;
  logic [3:0]  bitcnt;
  logic        stopcnt;
  logic        perr, ferr;
  logic        fall, decide, boundary, bit_maj, last_data, last_stop, strobe;

  // Bits arrive LSB-first into the top of shreg; shift down to LSB-align.
  function automatic logic [8:0] align(input logic [8:0] sh, input logic [3:0] n);
    return sh >> (4'd9 - n);
  endfunction

  uart_os_tick u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (state_q == IDLE),
    .i_clk_div (div_q),
    .o_tick    (tick)
  );

  assign fall      = rx_d & ~rx_s;
  assign decide    = tick && (tc == SAMPLE_C);
  assign boundary  = tick && (tc == TC_LAST);
  assign bit_maj   = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign last_data = (bitcnt == nbits_q - 4'd1);
  assign last_stop = (stopcnt == stop2_q);
  assign strobe    = i_rxen && (state_q == STOP) && decide && last_stop;
  assign o_busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    if (!i_rxen) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (fall) state_d = START;
        START:  if (decide && bit_maj) state_d = IDLE;
                else if (boundary) state_d = DATA;
        DATA:   if (boundary && last_data) state_d = parity_q ? PARITY : STOP;
        PARITY: if (boundary) state_d = STOP;
        // Leave on the decision, not the boundary, so a fast transmitter's
        // next start edge is caught in the second half of the stop bit.
        STOP:   if (decide && last_stop) state_d = (ferr | ~bit_maj) ? BREAK : IDLE;
        BREAK:  if (rx_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_d         <= 1'b1;
      nbits_q      <= 4'd8;
      stop2_q      <= 1'b0;
      parity_q     <= 1'b0;
      odd_q        <= 1'b0;
      div_q        <= '0;
      tc           <= '0;
      s7           <= 1'b1;
      s8           <= 1'b1;
      shreg        <= '0;
      bitcnt       <= '0;
      stopcnt      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      state_q <= state_d;
      o_valid <= strobe;

      if (state_q == IDLE) tc <= '0;
      else if (tick)       tc <= (tc == TC_LAST) ? 4'd0 : tc + 4'd1;

      if (tick && tc == SAMPLE_A) s7 <= rx_s;
      if (tick && tc == SAMPLE_B) s8 <= rx_s;

      if (!i_rxen) begin
        shreg <= '0;
      end else if (state_q == IDLE && fall) begin
        nbits_q  <= length_to_bits(i_length);
        stop2_q  <= i_stop2;
        parity_q <= i_parity;
        odd_q    <= i_odd;
        div_q    <= i_clk_div;
        shreg    <= '0;
        bitcnt   <= '0;
        stopcnt  <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end else begin
        if (state_q == DATA && decide)   shreg   <= {bit_maj, shreg[8:1]};
        if (state_q == DATA && boundary) bitcnt  <= bitcnt + 4'd1;
        if (state_q == PARITY && decide) perr    <= bit_maj ^ (^align(shreg, nbits_q)) ^ odd_q;
        if (state_q == STOP && decide)   ferr    <= ferr | ~bit_maj;
        if (state_q == STOP && boundary) stopcnt <= 1'b1;
        if (strobe) begin
          o_data       <= align(shreg, nbits_q);
          o_parity_err <= perr;
          o_frame_err  <= ferr | ~bit_maj;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand-built corner sequences,
// strobes checked against a queue of expected characters.
module tb_uart_rx;

  localparam int BIT = 32;  // clocks per bit with i_clk_div = 1

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_clk_div;
  logic        i_rxen;
  logic [1:0]  i_length;
  logic        i_stop2;
  logic        i_parity;
  logic        i_odd;
  logic        i_rx;
  logic [8:0]  o_data;
  logic        o_valid;
  logic        o_parity_err;
  logic        o_frame_err;
  logic        o_busy;

  uart_rx dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clk_div    (i_clk_div),
    .i_rxen       (i_rxen),
    .i_length     (i_length),
    .i_stop2      (i_stop2),
    .i_parity     (i_parity),
    .i_odd        (i_odd),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [1:0] len;
    logic       par;
    logic       odd;
    logic       stop2;
    logic [8:0] data;
    logic       flip;
    logic       bad_stop;
    int         gap;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   nstrobe = 0;
  int   snap;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_valid) begin
      nstrobe++;
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual data=%0h required=no strobe", o_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("data", 32'(o_data), 32'(mon_e.data));
        check("parity_err", 32'(o_parity_err), 32'(mon_e.perr));
        check("frame_err", 32'(o_frame_err), 32'(mon_e.ferr));
        check("busy_at_strobe", 32'(o_busy), 32'(mon_e.busy));
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (BIT) @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    e.busy = fe;  // a framing error parks the receiver in BREAK
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [1:0] len, input logic par, input logic odd,
                            input logic stop2, input logic [8:0] data, input logic flip,
                            input logic bad_stop, input int gap);
    int         n;
    logic [8:0] d;
    logic       pb;
    n  = 6 + int'(len);
    d  = 9'(data & ((9'd1 << n) - 9'd1));
    pb = (^d) ^ odd ^ flip;
    i_length = len;
    i_parity = par;
    i_odd    = odd;
    i_stop2  = stop2;
    drive_bit(1'b0);
    check("busy_in_frame", 32'(o_busy), 32'd1);
    // Scramble config mid-frame; only the latched copies may matter.
    i_length  = 2'($urandom);
    i_parity  = 1'($urandom);
    i_odd     = 1'($urandom);
    i_stop2   = 1'($urandom);
    i_clk_div = 16'($urandom_range(0, 7));
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (par) drive_bit(pb);
    if (stop2) drive_bit(1'b1);
    drive_bit(bad_stop ? 1'b0 : 1'b1);
    i_length  = len;
    i_parity  = par;
    i_odd     = odd;
    i_stop2   = stop2;
    i_clk_div = 16'd1;
    for (int g = 0; g < gap; g++) drive_bit(1'b1);
  endtask

  initial begin
    vecs[0] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'h048, 1'b0, 1'b0, 2, 9'h048, 1'b0, 1'b0};
    vecs[1] = '{2'd3, 1'b1, 1'b0, 1'b0, 9'h155, 1'b0, 1'b0, 0, 9'h155, 1'b0, 1'b0};
    vecs[2] = '{2'd3, 1'b1, 1'b0, 1'b0, 9'h1FF, 1'b0, 1'b0, 2, 9'h1FF, 1'b0, 1'b0};
    vecs[3] = '{2'd2, 1'b1, 1'b1, 1'b0, 9'h055, 1'b1, 1'b0, 2, 9'h055, 1'b1, 1'b0};
    vecs[4] = '{2'd2, 1'b1, 1'b1, 1'b0, 9'h031, 1'b0, 1'b0, 2, 9'h031, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 1'b0, 1'b0, 1'b1, 9'h1AB, 1'b0, 1'b0, 1, 9'h02B, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 1'b1, 1'b1, 1'b1, 9'h0C5, 1'b0, 1'b0, 1, 9'h045, 1'b0, 1'b0};
    vecs[7] = '{2'd3, 1'b1, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, 1, 9'h100, 1'b1, 1'b0};
    vecs[8] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1, 2, 9'h0A5, 1'b0, 1'b1};

    i_rst     = 1'b1;
    i_rx      = 1'b1;
    i_rxen    = 1'b1;
    i_clk_div = 16'd1;
    i_length  = 2'd2;
    i_stop2   = 1'b0;
    i_parity  = 1'b0;
    i_odd     = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_perr", 32'(o_parity_err), 32'd0);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;

    foreach (vecs[k]) begin
      push_exp(vecs[k].exp_data, vecs[k].exp_perr, vecs[k].exp_ferr);
      send_frame(vecs[k].len, vecs[k].par, vecs[k].odd, vecs[k].stop2, vecs[k].data,
                 vecs[k].flip, vecs[k].bad_stop, vecs[k].gap);
    end
    check("table_pending", 32'(exp_q.size()), 32'd0);
    check("table_strobes", 32'(nstrobe), 32'd9);

    // Short low glitch on an idle line: START must reject it.
    snap = nstrobe;
    i_rx = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_rx = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    check("glitch_busy_start", 32'(o_busy), 32'd1);
    repeat (60) @(posedge i_clk);
    #1;
    check("glitch_busy_idle", 32'(o_busy), 32'd0);
    check("glitch_no_strobe", 32'(nstrobe), 32'(snap));

    // Second stop bit low, then the line held low for three bit times.
    push_exp(9'h03C, 1'b0, 1'b1);
    send_frame(2'd2, 1'b0, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1, 0);
    snap = nstrobe;
    repeat (3 * BIT) @(posedge i_clk);
    #1;
    check("break_busy", 32'(o_busy), 32'd1);
    check("break_no_strobe", 32'(nstrobe), 32'(snap));
    i_rx = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    check("break_release", 32'(o_busy), 32'd0);
    push_exp(9'h05A, 1'b0, 1'b0);
    send_frame(2'd2, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0, 2);

    // Drop the enable in the middle of the data bits.
    snap = nstrobe;
    i_length = 2'd2;
    i_parity = 1'b0;
    i_stop2  = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (10) @(posedge i_clk);
    #1;
    i_rxen = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rxen_drop_busy", 32'(o_busy), 32'd0);
    i_rx = 1'b1;
    repeat (8) @(posedge i_clk);
    #1;
    i_rxen = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("rxen_no_strobe", 32'(nstrobe), 32'(snap));
    push_exp(9'h041, 1'b0, 1'b0);
    send_frame(2'd2, 1'b0, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0, 2);

    // Reset in the middle of the data bits.
    snap = nstrobe;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (10) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    i_rx  = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_data", 32'(o_data), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("midrst_no_strobe", 32'(nstrobe), 32'(snap));
    push_exp(9'h041, 1'b0, 1'b0);
    send_frame(2'd2, 1'b0, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0, 2);

    repeat (100) @(posedge i_clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_strobes", 32'(nstrobe), 32'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
